// File: rtl/pe_digit_serial_mac_if.sv
// Operand/result bundle for the digit-serial MAC processing element.
// The master side issues operands; the slave side (the PE) returns results.
interface pe_digit_serial_mac_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic                    acc_mode;
    logic                    acc_clr;
    logic [DATA_WIDTH-1:0]   c;
    logic [DATA_WIDTH-1:0]   d;
    logic                    out_valid;
    logic [2*DATA_WIDTH-1:0] C_out;
    logic [ACC_WIDTH-1:0]    acc_out;

    modport master (
        output in_valid, a, b, acc_mode, acc_clr,
        input  in_ready, c, d, out_valid, C_out, acc_out
    );

    modport slave (
        input  in_valid, a, b, acc_mode, acc_clr,
        output in_ready, c, d, out_valid, C_out, acc_out
    );
endinterface

// File: rtl/pe_digit_serial_mac.sv
// Digit-serial signed multiply-accumulate PE: one DIGIT_WIDTH x DIGIT_WIDTH partial
// product per cycle on operand magnitudes, with one exact slot and truncated others.
module pe_digit_serial_mac #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGIT_WIDTH = 4,
    parameter int EXACT_IDX   = 3,
    parameter int TRUNC_BITS  = 0,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+4
) (
    input logic                  fast_clk,
    input logic                  rst,
    pe_digit_serial_mac_if.slave bus
);
    localparam int N     = DATA_WIDTH / DIGIT_WIDTH;
    localparam int SLOTS = N * N;
    localparam int KW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int PPW   = 2 * DIGIT_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic [DATA_WIDTH-1:0] c_q, c_d, d_q, d_d;
    logic                  sign_q, sign_d, mode_q, mode_d;
    logic                  out_valid_q, out_valid_d;
    logic [KW-1:0]         k_q, k_d;
    logic [PW-1:0]         psum_q, psum_d, c_out_q, c_out_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;

    logic [PW-1:0]         slot_term [SLOTS];
    logic [PW-1:0]         term, sum_next, product;
    logic [ACC_WIDTH-1:0]  product_ext;
    logic                  final_edge;

    // Every slot's aligned partial product is built in parallel; k selects one per cycle.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            localparam int I = gi / N;
            localparam int J = gi % N;
            localparam logic [PPW-1:0] KEEP =
                (gi == EXACT_IDX) ? {PPW{1'b1}} : ~PPW'((2**TRUNC_BITS) - 1);
            logic [PPW-1:0] pp;
            assign pp = PPW'(a_mag_q[I*DIGIT_WIDTH +: DIGIT_WIDTH])
                      * PPW'(b_mag_q[J*DIGIT_WIDTH +: DIGIT_WIDTH]);
            assign slot_term[gi] = PW'(pp & KEEP) << ((I + J) * DIGIT_WIDTH);
        end
    endgenerate

    assign term        = slot_term[k_q];
    assign sum_next    = psum_q + term;
    assign product     = sign_q ? -sum_next : sum_next;
    assign product_ext = ACC_WIDTH'($signed(product));
    assign final_edge  = (state_q == RUN) && (k_q == KW'(SLOTS - 1));

    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        c_d         = c_q;
        d_d         = d_q;
        sign_d      = sign_q;
        mode_d      = mode_q;
        k_d         = k_q;
        psum_d      = psum_q;
        c_out_d     = c_out_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Magnitudes are unsigned, so -2^(W-1) becomes 2^(W-1) without overflow.
                    a_mag_d = bus.a[DATA_WIDTH-1] ? -bus.a : bus.a;
                    b_mag_d = bus.b[DATA_WIDTH-1] ? -bus.b : bus.b;
                    sign_d  = bus.a[DATA_WIDTH-1] ^ bus.b[DATA_WIDTH-1];
                    mode_d  = bus.acc_mode;
                    c_d     = bus.a;
                    d_d     = bus.b;
                    k_d     = '0;
                    psum_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                psum_d = sum_next;
                k_d    = k_q + 1'b1;
                if (final_edge) begin
                    c_out_d     = product;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    if (bus.acc_clr || !mode_q) acc_d = product_ext;
                    else                        acc_d = acc_q + product_ext;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.acc_clr && !final_edge) acc_d = '0;
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            c_q         <= '0;
            d_q         <= '0;
            sign_q      <= 1'b0;
            mode_q      <= 1'b0;
            k_q         <= '0;
            psum_q      <= '0;
            c_out_q     <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            c_q         <= c_d;
            d_q         <= d_d;
            sign_q      <= sign_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            psum_q      <= psum_d;
            c_out_q     <= c_out_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.c         = c_q;
    assign bus.d         = d_q;
    assign bus.out_valid = out_valid_q;
    assign bus.C_out     = c_out_q;
    assign bus.acc_out   = acc_q;
endmodule

// File: doc/pe_digit_serial_mac.md
Name: pe_digit_serial_mac

Overview:
- Parametrised successor to the three-cycle 8-bit split-nibble PEs; the next-generation systolic processing element for the approximate-multiplier arrays.
- Computes a signed DATA_WIDTH x DATA_WIDTH product digit-serially, one DIGIT_WIDTH x DIGIT_WIDTH partial product per fast_clk cycle.
- Exactly one partial-product slot (EXACT_IDX) uses the exact sub-multiplier; all other slots use the truncating approximate sub-multiplier.
- Adds a valid/ready input handshake, an output valid strobe and an optional accumulate (MAC) mode.

Parameters:
DATA_WIDTH, 8, operand width; must be a multiple of DIGIT_WIDTH.
DIGIT_WIDTH, 4, sub-multiplier width. N = DATA_WIDTH/DIGIT_WIDTH; total slots = N*N.
EXACT_IDX, 3, slot index k (0..N*N-1) computed exactly.
TRUNC_BITS, 0, low bits forced to 0 in approximate partial products (0 makes every slot exact).
ACC_WIDTH, 2*DATA_WIDTH+4, accumulator width.

Ports:
fast_clk  in  1  sole clock.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  operands valid.
in_ready  out  1  PE idle and able to accept.
a, b  in  DATA_WIDTH  signed operands.
acc_mode  in  1  sampled at accept: 0 = overwrite, 1 = accumulate.
acc_clr  in  1  synchronous accumulator clear.
c, d  out  DATA_WIDTH  systolic forwarded copies of a and b.
out_valid  out  1  one-cycle result strobe.
C_out  out  2*DATA_WIDTH  signed product, held until the next result.
acc_out  out  ACC_WIDTH  signed accumulator.

Behaviour:
- Reset: all outputs 0 except in_ready = 1; state IDLE. Reset mid-operation aborts the operation with no out_valid.
- States: IDLE, RUN.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid at a rising edge E.
  - Latch |a| and |b| as DATA_WIDTH-bit unsigned values (so -2^(W-1) maps to 2^(W-1)), sign = a[msb]^b[msb], and acc_mode.
  - c <= a, d <= b. c and d update only on accept.
  - k <= 0, psum <= 0, go to RUN.
- RUN:
  - in_ready = 0. in_valid is ignored and c/d stay unchanged.
  - Each edge processes slot k: i = k / N (digit of |a|), j = k mod N (digit of |b|).
  - pp = ai*bj, 2*DIGIT_WIDTH bits.
  - If k != EXACT_IDX, clear the low TRUNC_BITS bits of pp.
  - psum += pp << ((i+j)*DIGIT_WIDTH). psum is 2*DATA_WIDTH bits, unsigned.
  - Slots are processed at edges E+1 .. E+N*N.
- Final edge (k = N*N-1, edge E+N*N):
  - C_out <= sign ? -(psum+pp_last) : (psum+pp_last).
  - out_valid <= 1 for exactly one cycle.
  - acc_out update, with the product sign-extended to ACC_WIDTH: acc_clr=1 -> product; acc_mode=0 -> product; otherwise acc_out + product, wrapping modulo 2^ACC_WIDTH.
  - Return to IDLE.
- Latency: out_valid is high in the cycle after edge E+N*N. Throughput: one operation per N*N+1 cycles.
- acc_clr outside a final edge sets acc_out <= 0 on that edge. C_out is unaffected.
- Zero operand: full run, product 0; -0 is never produced.

Test Plan:
1. Defaults, a=13, b=-7 -> after 4 RUN edges, out_valid one cycle, C_out=0xFFA5 (-91), c=13, d=-7, in_ready high again.
2. a=-128, b=-128 -> C_out=0x4000 (16384). a=-128, b=127 -> 0xC080 (-16256).
3. TRUNC_BITS=2, EXACT_IDX=3, a=b=0x33 -> C_out = 8 + 128 + 128 + 2304 = 2568 (exact value 2601).
4. acc_mode=0 with 10*10 -> acc_out=100. Then acc_mode=1 with -5*3 -> acc_out=85. Then acc_clr alone -> acc_out=0. Then acc_clr coincident with a final edge of 6*6 under acc_mode=1 -> acc_out=36.
5. Hold in_valid high with changing operands during RUN -> ignored, c/d stable. The next op is accepted the cycle after out_valid rises; back-to-back results are spaced 5 cycles apart.
6. Assert rst at RUN edge 2 -> all outputs 0, no out_valid, in_ready=1. A subsequent 3*4 yields C_out=12.
